// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Serialises split instruction/data requests onto one shared
//                memory port, data first, with a per-transaction timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int          TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_read,
    input  logic [31:0] inst_addr,
    output logic        inst_resp,
    output logic [31:0] inst_rdata,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_mbe,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_resp,
    output logic [31:0] data_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mbe,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        timeout_err
);

    localparam int                  c_CNT_W    = $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SERVE_I = 2'd1,
        S_SERVE_D = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_is_data;
    logic                 r_is_write;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [3:0]           r_mbe;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [31:0]          r_inst_rdata;
    logic [31:0]          r_data_rdata;
    logic                 r_timeout_err;
    logic                 w_data_req;
    logic                 w_expire;

    assign w_data_req = data_read | data_write;
    assign w_expire   = !mem_resp && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Strobes and responses decode purely from the registered state.
    always_comb begin
        w_next    = r_state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        inst_resp = 1'b0;
        data_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_data_req) begin
                    w_next = S_SERVE_D;
                end else if (inst_read) begin
                    w_next = S_SERVE_I;
                end
            end
            S_SERVE_I, S_SERVE_D: begin
                mem_read  = !r_is_write;
                mem_write = r_is_write;
                if (mem_resp || w_expire) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                inst_resp = !r_is_data;
                data_resp = r_is_data;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_data     <= 1'b0;
            r_is_write    <= 1'b0;
            r_addr        <= 32'd0;
            r_wdata       <= 32'd0;
            r_mbe         <= 4'd0;
            r_cnt         <= '0;
            r_inst_rdata  <= 32'd0;
            r_data_rdata  <= 32'd0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_data_req) begin
                        r_is_data  <= 1'b1;
                        r_is_write <= data_write;
                        r_addr     <= data_addr;
                        r_wdata    <= data_wdata;
                        r_mbe      <= data_write ? data_mbe : 4'hF;
                        r_cnt      <= '0;
                    end else if (inst_read) begin
                        r_is_data  <= 1'b0;
                        r_is_write <= 1'b0;
                        r_addr     <= inst_addr;
                        r_wdata    <= 32'd0;
                        r_mbe      <= 4'hF;
                        r_cnt      <= '0;
                    end
                end
                S_SERVE_I, S_SERVE_D: begin
                    if (mem_resp) begin
                        if (!r_is_write) begin
                            if (r_is_data) r_data_rdata <= mem_rdata;
                            else           r_inst_rdata <= mem_rdata;
                        end
                    end else if (w_expire) begin
                        // Writes carry no read data, so only reads see ERR_DATA.
                        r_timeout_err <= 1'b1;
                        if (!r_is_write) begin
                            if (r_is_data) r_data_rdata <= ERR_DATA;
                            else           r_inst_rdata <= ERR_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign mem_mbe     = r_mbe;
    assign inst_rdata  = r_inst_rdata;
    assign data_rdata  = r_data_rdata;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed bench with a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int          TIMEOUT  = 8;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        inst_read = 1'b0;
    logic [31:0] inst_addr = 32'd0;
    logic        inst_resp;
    logic [31:0] inst_rdata;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [3:0]  data_mbe = 4'd0;
    logic [31:0] data_addr = 32'd0;
    logic [31:0] data_wdata = 32'd0;
    logic        data_resp;
    logic [31:0] data_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mbe;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_resp = 1'b0;
    logic        timeout_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
        .clk(clk), .reset(reset),
        .inst_read(inst_read), .inst_addr(inst_addr),
        .inst_resp(inst_resp), .inst_rdata(inst_rdata),
        .data_read(data_read), .data_write(data_write), .data_mbe(data_mbe),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_resp(data_resp), .data_rdata(data_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mbe(mem_mbe),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .timeout_err(timeout_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one in-flight transaction record plus a pending response.
    int          cycle = 0;
    bit          m_valid;
    bit          m_is_data;
    bit          m_is_write;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_mbe;
    int          m_grant_cyc;
    int          m_resp_who;      // 0 none, 1 inst, 2 data
    logic [31:0] m_inst_rdata, m_data_rdata;
    bit          m_err;

    task automatic m_finish(input logic [31:0] rd);
        if (!m_is_write) begin
            if (m_is_data) m_data_rdata = rd;
            else           m_inst_rdata = rd;
        end
        m_resp_who = m_is_data ? 2 : 1;
        m_valid    = 1'b0;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid = 0; m_is_data = 0; m_is_write = 0;
            m_addr = 0; m_wdata = 0; m_mbe = 0; m_grant_cyc = 0;
            m_resp_who = 0; m_inst_rdata = 0; m_data_rdata = 0; m_err = 0;
        end else begin
            cycle = cycle + 1;
            if (m_resp_who != 0) begin
                m_resp_who = 0;
            end else if (m_valid) begin
                if (mem_resp) begin
                    m_finish(mem_rdata);
                end else if (cycle - m_grant_cyc == TIMEOUT) begin
                    m_err = 1'b1;
                    m_finish(ERR_DATA);
                end
            end else if (data_read || data_write) begin
                m_valid = 1; m_is_data = 1; m_is_write = data_write;
                m_addr = data_addr; m_wdata = data_wdata;
                m_mbe = data_write ? data_mbe : 4'hF;
                m_grant_cyc = cycle;
            end else if (inst_read) begin
                m_valid = 1; m_is_data = 0; m_is_write = 0;
                m_addr = inst_addr; m_wdata = 0; m_mbe = 4'hF;
                m_grant_cyc = cycle;
            end
        end
    end

    always @(negedge clk) begin
        check("mem_read",    32'(mem_read),    32'(m_valid && !m_is_write));
        check("mem_write",   32'(mem_write),   32'(m_valid && m_is_write));
        check("mem_addr",    mem_addr,         m_addr);
        check("mem_wdata",   mem_wdata,        m_wdata);
        check("mem_mbe",     32'(mem_mbe),     32'(m_mbe));
        check("inst_resp",   32'(inst_resp),   32'(m_resp_who == 1));
        check("data_resp",   32'(data_resp),   32'(m_resp_who == 2));
        check("inst_rdata",  inst_rdata,       m_inst_rdata);
        check("data_rdata",  data_rdata,       m_data_rdata);
        check("timeout_err", 32'(timeout_err), 32'(m_err));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(output int s);
        s = -1;
        for (int k = 0; k < 40; k++) begin
            if (mem_read || mem_write) begin
                s = cycle;
                break;
            end
            tick();
        end
        check("strobe_seen", 32'(s >= 0), 32'd1);
    endtask

    task automatic wait_resp(output int r);
        r = -1;
        for (int k = 0; k < 40; k++) begin
            if (inst_resp || data_resp) begin
                r = cycle;
                break;
            end
            tick();
        end
        check("resp_seen", 32'(r >= 0), 32'd1);
    endtask

    task automatic mem_reply(input int delay, input logic [31:0] rd);
        repeat (delay) tick();
        mem_resp  = 1'b1;
        mem_rdata = rd;
        tick();
        mem_resp  = 1'b0;
    endtask

    int t, s, r;

    initial begin
        #12;
        check("rst_mem_addr",  mem_addr, 32'd0);
        check("rst_strobes",   32'({mem_read, mem_write}), 32'd0);
        check("rst_resps",     32'({inst_resp, data_resp}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        tick();

        // Spurious mem_resp while idle
        mem_resp = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        mem_resp = 1'b0;
        check("idle_spurious", 32'({inst_resp, data_resp, mem_read}), 32'd0);
        tick();

        // Instruction read, mem_resp two cycles into the strobe
        inst_addr = 32'h60; inst_read = 1'b1; t = cycle;
        wait_strobe(s);
        check("t2_strobe_lat", 32'(s - t), 32'd1);
        check("t2_mem_addr", mem_addr, 32'h60);
        check("t2_mem_mbe", 32'(mem_mbe), 32'hF);
        mem_reply(2, 32'h0000_0013);
        wait_resp(r);
        check("t2_resp_lat", 32'(r - s), 32'd3);
        check("t2_inst_rdata", inst_rdata, 32'h0000_0013);
        inst_read = 1'b0;
        mem_resp = 1'b1;                    // spurious during the response cycle
        tick();
        mem_resp = 1'b0;
        check("done_spurious", 32'({inst_resp, data_resp, mem_read}), 32'd0);
        tick();

        // Simultaneous inst + data write: write goes first
        inst_addr = 32'h200; inst_read = 1'b1;
        data_addr = 32'h100; data_wdata = 32'hA5A5_A5A5; data_mbe = 4'b0011; data_write = 1'b1;
        wait_strobe(s);
        check("t3_write_first", 32'({mem_write, mem_read}), 32'b10);
        check("t3_wr_addr", mem_addr, 32'h100);
        check("t3_wr_data", mem_wdata, 32'hA5A5_A5A5);
        check("t3_wr_mbe", 32'(mem_mbe), 32'b0011);
        mem_reply(1, 32'hFFFF_0000);
        wait_resp(r);
        check("t3_data_resp", 32'({data_resp, inst_resp}), 32'b10);
        check("t3_wr_rdata_kept", data_rdata, 32'd0);
        data_write = 1'b0;
        wait_strobe(s);
        check("t3_inst_read", 32'({mem_write, mem_read}), 32'b01);
        check("t3_inst_addr", mem_addr, 32'h200);
        mem_reply(0, 32'h0BAD_F00D);
        wait_resp(r);
        check("t3_inst_rdata", inst_rdata, 32'h0BAD_F00D);
        inst_read = 1'b0;
        tick();

        // Inputs change after grant; captured values must hold
        data_addr = 32'h300; data_wdata = 32'h1111_2222; data_mbe = 4'b1100; data_write = 1'b1;
        wait_strobe(s);
        data_addr = 32'hFFF0; data_wdata = 32'd0; data_mbe = 4'hF;
        repeat (3) tick();
        check("t5_addr_held", mem_addr, 32'h300);
        check("t5_wdata_held", mem_wdata, 32'h1111_2222);
        check("t5_mbe_held", 32'(mem_mbe), 32'b1100);
        mem_reply(0, 32'd0);
        wait_resp(r);
        data_write = 1'b0;
        tick();

        // Data read that never sees mem_resp: response in the 9th cycle counted from the first strobe cycle
        data_addr = 32'h400; data_read = 1'b1;
        wait_strobe(s);
        wait_resp(r);
        check("t4_timeout_lat", 32'(r - s), 32'(TIMEOUT));
        check("t4_err_data", data_rdata, 32'hDEAD_BEEF);
        check("t4_err_flag", 32'(timeout_err), 32'd1);
        data_read = 1'b0;
        tick();

        // Normal read afterwards; error flag stays set
        data_addr = 32'h404; data_read = 1'b1;
        wait_strobe(s);
        mem_reply(1, 32'h1234_5678);
        wait_resp(r);
        check("sticky_rdata", data_rdata, 32'h1234_5678);
        check("sticky_err", 32'(timeout_err), 32'd1);
        data_read = 1'b0;
        tick();

        // Read and write together behave as a write
        data_addr = 32'h500; data_wdata = 32'h77; data_mbe = 4'b0101;
        data_read = 1'b1; data_write = 1'b1;
        wait_strobe(s);
        check("rw_is_write", 32'({mem_write, mem_read}), 32'b10);
        mem_reply(0, 32'h99);
        wait_resp(r);
        check("rw_rdata_kept", data_rdata, 32'h1234_5678);
        data_read = 1'b0; data_write = 1'b0;
        tick();

        // Asynchronous reset in the middle of a write
        data_addr = 32'h600; data_wdata = 32'h42; data_mbe = 4'hF; data_write = 1'b1;
        wait_strobe(s);
        #2;
        reset = 1'b0;
        #1;
        check("t1_mem_write", 32'(mem_write), 32'd0);
        check("t1_data_resp", 32'(data_resp), 32'd0);
        check("t1_timeout_err", 32'(timeout_err), 32'd0);
        check("t1_mem_addr", mem_addr, 32'd0);
        data_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
